// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM:
// states, opcode constants, pc_op and trap_cause codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM_WAIT  = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [3:0] OP_LOAD   = 4'b0110;
  localparam logic [3:0] OP_STORE  = 4'b0111;
  localparam logic [3:0] OP_LDI    = 4'b1000;
  localparam logic [3:0] OP_BRANCH = 4'b1101;
  localparam logic [3:0] OP_JUMP   = 4'b1110;
  localparam logic [3:0] OP_ILL    = 4'b1111;

  localparam logic [1:0] PC_CLR  = 2'b00;
  localparam logic [1:0] PC_LOAD = 2'b01;
  localparam logic [1:0] PC_INC  = 2'b10;
  localparam logic [1:0] PC_HOLD = 2'b11;

  localparam logic [1:0] TC_NONE = 2'b00;
  localparam logic [1:0] TC_ILL  = 2'b01;
  localparam logic [1:0] TC_TMO  = 2'b10;

  typedef struct packed {
    logic alu;
    logic load;
    logic store;
    logic ldi;
    logic branch;
    logic jump;
  } op_cls_t;

endpackage

// File: rtl/op_classify.sv
// Opcode classifier: one-hot instruction class plus illegal flag.
// Any set bit above bit 3 makes the opcode illegal.
module op_classify
  import ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  output op_cls_t        cls,
  output logic           illegal
);

  logic       upper;
  logic [3:0] lo;

  if (OPW > 4) begin : g_hi
    assign upper = |opcode[OPW-1:4];
  end else begin : g_lo
    assign upper = 1'b0;
  end

  assign lo = opcode[3:0];

  always_comb begin
    cls     = '0;
    illegal = upper || (lo == OP_ILL);
    if (!illegal) begin
      unique case (lo)
        OP_LOAD:   cls.load   = 1'b1;
        OP_STORE:  cls.store  = 1'b1;
        OP_LDI:    cls.ldi    = 1'b1;
        OP_BRANCH: cls.branch = 1'b1;
        OP_JUMP:   cls.jump   = 1'b1;
        default:   cls.alu    = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle processor control FSM with memory-wait timeout
// and illegal-opcode trap handling.
module mc_control_fsm
  import ctrl_pkg::*;
#(
  parameter int OPW      = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           flag,
  input  logic           mem_ready,
  input  logic           trap_clr,
  output logic           inst_wr,
  output logic           en_reg,
  output logic           regD_wr,
  output logic           imm_en,
  output logic           adrs_ctrl,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic [1:0]     pc_op,
  output logic           trap,
  output logic [1:0]     trap_cause,
  output logic [2:0]     state_o
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  state_t         state;
  logic [OPW-1:0] op_q;
  logic [CW-1:0]  cnt;
  logic [1:0]     cause_q;
  op_cls_t        cls;
  logic           illegal;
  logic           cnt_max;
  logic           is_mem;

  op_classify #(.OPW(OPW)) u_cls (
    .opcode  (op_q),
    .cls     (cls),
    .illegal (illegal)
  );

  assign cnt_max = (cnt == CW'(WAIT_MAX));
  assign is_mem  = cls.load | cls.store;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      op_q    <= '0;
      cnt     <= '0;
      cause_q <= TC_NONE;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (mem_ready) begin
            op_q  <= opcode;
            cnt   <= '0;
            state <= S_DECODE;
          end else if (cnt_max) begin
            cause_q <= TC_TMO;
            state   <= S_TRAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DECODE: begin
          if (illegal) begin
            cause_q <= TC_ILL;
            state   <= S_TRAP;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          cnt   <= '0;
          state <= is_mem ? S_MEM_WAIT : S_WRITEBACK;
        end
        S_MEM_WAIT: begin
          // a completing access beats a timeout on the same cycle
          if (mem_ready) begin
            state <= S_WRITEBACK;
          end else if (cnt_max) begin
            cause_q <= TC_TMO;
            state   <= S_TRAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WRITEBACK: begin
          cnt   <= '0;
          state <= S_FETCH;
        end
        S_TRAP: begin
          if (trap_clr) begin
            cnt     <= '0;
            cause_q <= TC_NONE;
            state   <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    inst_wr   = 1'b0;
    en_reg    = 1'b0;
    regD_wr   = 1'b0;
    imm_en    = 1'b0;
    adrs_ctrl = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    pc_op     = PC_HOLD;
    trap      = 1'b0;
    unique case (state)
      S_FETCH: begin
        inst_wr   = 1'b1;
        adrs_ctrl = 1'b1;
        mem_rd    = 1'b1;
      end
      S_DECODE: begin
        en_reg    = 1'b1;
        imm_en    = is_mem;
        adrs_ctrl = !is_mem;
      end
      S_EXECUTE: begin
        unique case (1'b1)
          cls.alu: begin
            en_reg    = 1'b1;
            adrs_ctrl = 1'b1;
          end
          cls.ldi:   imm_en = 1'b1;
          cls.load:  imm_en = 1'b1;
          cls.store: imm_en = 1'b1;
          cls.branch: begin
            if (!flag) begin
              pc_op  = PC_LOAD;
              imm_en = 1'b1;
            end
          end
          cls.jump: begin
            pc_op  = PC_LOAD;
            imm_en = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM_WAIT: begin
        imm_en = 1'b1;
        mem_rd = cls.load;
        mem_wr = cls.store;
      end
      S_WRITEBACK: begin
        en_reg  = 1'b1;
        regD_wr = cls.alu | cls.ldi | cls.load;
        pc_op   = (cls.branch | cls.jump) ? PC_HOLD : PC_INC;
      end
      S_TRAP: begin
        trap = 1'b1;
        if (trap_clr) pc_op = PC_CLR;
      end
      default: ;
    endcase
    if (reset) pc_op = PC_CLR;
  end

  assign trap_cause = cause_q;
  assign state_o    = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed vector bench for mc_control_fsm: table of per-cycle
// inputs and expected outputs, plus timeout and reset sequences.
module tb_mc_control_fsm;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       flag;
  logic       mem_ready;
  logic       trap_clr;
  logic       inst_wr, en_reg, regD_wr, imm_en;
  logic       adrs_ctrl, mem_rd, mem_wr, trap;
  logic [1:0] pc_op, trap_cause;
  logic [2:0] state_o;

  mc_control_fsm #(.OPW(4), .WAIT_MAX(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .flag       (flag),
    .mem_ready  (mem_ready),
    .trap_clr   (trap_clr),
    .inst_wr    (inst_wr),
    .en_reg     (en_reg),
    .regD_wr    (regD_wr),
    .imm_en     (imm_en),
    .adrs_ctrl  (adrs_ctrl),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .pc_op      (pc_op),
    .trap       (trap),
    .trap_cause (trap_cause),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobes packed as {inst_wr,en_reg,regD_wr,imm_en,adrs_ctrl,mem_rd,mem_wr}
  localparam logic [6:0] FE    = 7'b1000110;
  localparam logic [6:0] DEC_R = 7'b0100100;
  localparam logic [6:0] DEC_M = 7'b0101000;
  localparam logic [6:0] EX_A  = 7'b0100100;
  localparam logic [6:0] EX_I  = 7'b0001000;
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] MW_LD = 7'b0001010;
  localparam logic [6:0] MW_ST = 7'b0001001;
  localparam logic [6:0] WB_W  = 7'b0110000;
  localparam logic [6:0] WB_N  = 7'b0100000;

  typedef struct {
    string       name;
    int          rst;
    int          op;
    int          flg;
    int          rdy;
    int          clr;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   nvec;
  int   nfail;

  function automatic logic [14:0] X(input int st, input logic [6:0] s,
                                    input int pc, input int tr,
                                    input int tc);
    return {3'(st), s, 2'(pc), 1'(tr), 2'(tc)};
  endfunction

  task automatic add(input string n, input int r, input int op,
                     input int f, input int rd, input int c,
                     input logic [14:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.op = op;
    v.flg = f; v.rdy = rd; v.clr = c; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    logic [14:0] act;
    @(negedge clk);
    reset     = 1'(v.rst);
    opcode    = 4'(v.op);
    flag      = 1'(v.flg);
    mem_ready = 1'(v.rdy);
    trap_clr  = 1'(v.clr);
    #1;
    act = {state_o, inst_wr, en_reg, regD_wr, imm_en, adrs_ctrl,
           mem_rd, mem_wr, pc_op, trap, trap_cause};
    nvec++;
    if (act !== v.exp) begin
      nfail++;
      $display("FAIL %s: got %b required %b", v.name, act, v.exp);
    end
  endtask

  task automatic chk(input string n, input int r, input int op,
                     input int f, input int rd, input int c,
                     input logic [14:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.op = op;
    v.flg = f; v.rdy = rd; v.clr = c; v.exp = e;
    apply(v);
  endtask

  initial begin
    nvec = 0; nfail = 0;
    reset = 1'b1; opcode = '0; flag = 1'b0;
    mem_ready = 1'b0; trap_clr = 1'b0;

    add("rst0", 1, 0, 0, 1, 0, X(0, FE, 0, 0, 0));
    add("rst1", 1, 0, 0, 1, 1, X(0, FE, 0, 0, 0));
    // ADD; later opcode changes and mem_ready must be ignored
    add("add_f", 0, 0, 0, 1, 0, X(0, FE, 3, 0, 0));
    add("add_d", 0, 5, 0, 0, 0, X(1, DEC_R, 3, 0, 0));
    add("add_e", 0, 6, 0, 1, 0, X(2, EX_A, 3, 0, 0));
    add("add_w", 0, 7, 0, 0, 0, X(4, WB_W, 2, 0, 0));
    // LOAD with fetch wait and 3 low MEM_WAIT cycles
    add("ld_fw", 0, 6, 0, 0, 0, X(0, FE, 3, 0, 0));
    add("ld_f",  0, 6, 0, 1, 0, X(0, FE, 3, 0, 0));
    add("ld_d",  0, 0, 0, 1, 0, X(1, DEC_M, 3, 0, 0));
    add("ld_e",  0, 0, 0, 1, 0, X(2, EX_I, 3, 0, 0));
    add("ld_m1", 0, 0, 0, 0, 0, X(3, MW_LD, 3, 0, 0));
    add("ld_m2", 0, 0, 0, 0, 0, X(3, MW_LD, 3, 0, 0));
    add("ld_m3", 0, 0, 0, 0, 0, X(3, MW_LD, 3, 0, 0));
    add("ld_m4", 0, 0, 0, 1, 0, X(3, MW_LD, 3, 0, 0));
    add("ld_w",  0, 0, 0, 0, 0, X(4, WB_W, 2, 0, 0));
    // BRANCH not taken-flag / taken-flag, JUMP, LDI, STORE, ALU 1001/1100
    add("br0_f", 0, 13, 0, 1, 0, X(0, FE, 3, 0, 0));
    add("br0_d", 0, 0, 0, 1, 0, X(1, DEC_R, 3, 0, 0));
    add("br0_e", 0, 0, 0, 1, 0, X(2, EX_I, 1, 0, 0));
    add("br0_w", 0, 0, 0, 1, 0, X(4, WB_N, 3, 0, 0));
    add("br1_f", 0, 13, 1, 1, 0, X(0, FE, 3, 0, 0));
    add("br1_d", 0, 0, 1, 1, 0, X(1, DEC_R, 3, 0, 0));
    add("br1_e", 0, 0, 1, 1, 0, X(2, NONE, 3, 0, 0));
    add("br1_w", 0, 0, 1, 1, 0, X(4, WB_N, 3, 0, 0));
    add("jmp_f", 0, 14, 1, 1, 0, X(0, FE, 3, 0, 0));
    add("jmp_d", 0, 0, 1, 1, 0, X(1, DEC_R, 3, 0, 0));
    add("jmp_e", 0, 0, 1, 1, 0, X(2, EX_I, 1, 0, 0));
    add("jmp_w", 0, 0, 1, 1, 0, X(4, WB_N, 3, 0, 0));
    add("ldi_f", 0, 8, 0, 1, 0, X(0, FE, 3, 0, 0));
    add("ldi_d", 0, 0, 0, 1, 0, X(1, DEC_R, 3, 0, 0));
    add("ldi_e", 0, 0, 0, 1, 0, X(2, EX_I, 3, 0, 0));
    add("ldi_w", 0, 0, 0, 1, 0, X(4, WB_W, 2, 0, 0));
    add("st_f",  0, 7, 0, 1, 0, X(0, FE, 3, 0, 0));
    add("st_d",  0, 0, 0, 0, 0, X(1, DEC_M, 3, 0, 0));
    add("st_e",  0, 0, 0, 0, 0, X(2, EX_I, 3, 0, 0));
    add("st_m",  0, 0, 0, 1, 0, X(3, MW_ST, 3, 0, 0));
    add("st_w",  0, 0, 0, 1, 0, X(4, WB_N, 2, 0, 0));
    add("a9_f",  0, 9, 0, 1, 0, X(0, FE, 3, 0, 0));
    add("a9_d",  0, 0, 0, 1, 0, X(1, DEC_R, 3, 0, 0));
    add("a9_e",  0, 0, 0, 1, 0, X(2, EX_A, 3, 0, 0));
    add("a9_w",  0, 0, 0, 1, 0, X(4, WB_W, 2, 0, 0));
    add("ac_f",  0, 12, 0, 1, 0, X(0, FE, 3, 0, 0));
    add("ac_d",  0, 0, 0, 1, 0, X(1, DEC_R, 3, 0, 0));
    add("ac_e",  0, 0, 0, 1, 0, X(2, EX_A, 3, 0, 0));
    add("ac_w",  0, 0, 0, 1, 0, X(4, WB_W, 2, 0, 0));
    // illegal opcode: trap_clr before TRAP must be ignored
    add("il_f",  0, 15, 0, 1, 0, X(0, FE, 3, 0, 0));
    add("il_d",  0, 0, 0, 1, 1, X(1, DEC_R, 3, 0, 0));
    for (int i = 0; i < 5; i++)
      add("il_hold", 0, 0, 0, 1, 0, X(5, NONE, 3, 1, 1));
    add("il_clr", 0, 0, 0, 1, 1, X(5, NONE, 0, 1, 1));
    add("il_fe",  0, 0, 0, 0, 0, X(0, FE, 3, 0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // STORE timeout: 16 low MEM_WAIT cycles then TRAP cause 10
    chk("to_f", 0, 7, 0, 1, 0, X(0, FE, 3, 0, 0));
    chk("to_d", 0, 0, 0, 1, 0, X(1, DEC_M, 3, 0, 0));
    chk("to_e", 0, 0, 0, 1, 0, X(2, EX_I, 3, 0, 0));
    for (int i = 0; i < 16; i++)
      chk("to_mw", 0, 0, 0, 0, 0, X(3, MW_ST, 3, 0, 0));
    chk("to_trap", 0, 0, 0, 1, 0, X(5, NONE, 3, 1, 2));
    chk("to_clr",  0, 0, 0, 1, 1, X(5, NONE, 0, 1, 2));

    // mem_ready on the 15th wait cycle completes the access
    chk("r15_f", 0, 7, 0, 1, 0, X(0, FE, 3, 0, 0));
    chk("r15_d", 0, 0, 0, 1, 0, X(1, DEC_M, 3, 0, 0));
    chk("r15_e", 0, 0, 0, 1, 0, X(2, EX_I, 3, 0, 0));
    for (int i = 0; i < 14; i++)
      chk("r15_mw", 0, 0, 0, 0, 0, X(3, MW_ST, 3, 0, 0));
    chk("r15_rdy", 0, 0, 0, 1, 0, X(3, MW_ST, 3, 0, 0));
    chk("r15_w",   0, 0, 0, 0, 0, X(4, WB_N, 2, 0, 0));

    // mem_ready on the counter==WAIT_MAX cycle wins over timeout
    chk("r16_f", 0, 7, 0, 1, 0, X(0, FE, 3, 0, 0));
    chk("r16_d", 0, 0, 0, 1, 0, X(1, DEC_M, 3, 0, 0));
    chk("r16_e", 0, 0, 0, 1, 0, X(2, EX_I, 3, 0, 0));
    for (int i = 0; i < 15; i++)
      chk("r16_mw", 0, 0, 0, 0, 0, X(3, MW_ST, 3, 0, 0));
    chk("r16_rdy", 0, 0, 0, 1, 0, X(3, MW_ST, 3, 0, 0));
    chk("r16_w",   0, 0, 0, 0, 0, X(4, WB_N, 2, 0, 0));

    // asynchronous reset in the middle of a STORE wait
    chk("rs_f",  0, 7, 0, 1, 0, X(0, FE, 3, 0, 0));
    chk("rs_d",  0, 0, 0, 1, 0, X(1, DEC_M, 3, 0, 0));
    chk("rs_e",  0, 0, 0, 1, 0, X(2, EX_I, 3, 0, 0));
    chk("rs_m1", 0, 0, 0, 0, 0, X(3, MW_ST, 3, 0, 0));
    chk("rs_m2", 0, 0, 0, 0, 0, X(3, MW_ST, 3, 0, 0));
    chk("rs_now", 1, 0, 0, 0, 0, X(0, FE, 0, 0, 0));
    chk("rs_hold", 1, 0, 0, 1, 0, X(0, FE, 0, 0, 0));
    chk("rs_af", 0, 0, 0, 1, 0, X(0, FE, 3, 0, 0));
    chk("rs_ad", 0, 0, 0, 1, 0, X(1, DEC_R, 3, 0, 0));
    chk("rs_ae", 0, 0, 0, 1, 0, X(2, EX_A, 3, 0, 0));
    chk("rs_aw", 0, 0, 0, 1, 0, X(4, WB_W, 2, 0, 0));
    chk("rs_nf", 0, 0, 0, 0, 0, X(0, FE, 3, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter OPW, default 4: opcode width; SHALL be >= 4.
REQ-002 Parameter WAIT_MAX, default 15: maximum memory wait cycles before a timeout trap; SHALL be >= 1.
REQ-003 Port clk, input, 1: single clock; all state changes SHALL occur on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port opcode, input, OPW: instruction opcode; sampled only on the FETCH->DECODE transition.
REQ-006 Port flag, input, 1: ALU zero flag; sampled in EXECUTE.
REQ-007 Port mem_ready, input, 1: memory handshake; 1 = current access complete this cycle.
REQ-008 Port trap_clr, input, 1: clears TRAP state.
REQ-009 Port inst_wr, output, 1: instruction register write.
REQ-010 Port en_reg, output, 1: register-file read enable.
REQ-011 Port regD_wr, output, 1: destination register write.
REQ-012 Port imm_en, output, 1: immediate operand select.
REQ-013 Port adrs_ctrl, output, 1: memory address source (1 = PC, 0 = ALU/immediate).
REQ-014 Port mem_rd, output, 1: memory read strobe.
REQ-015 Port mem_wr, output, 1: memory write strobe.
REQ-016 Port pc_op, output, 2: 00 clear, 01 load branch target, 10 increment, 11 hold.
REQ-017 Port trap, output, 1: FSM is in TRAP.
REQ-018 Port trap_cause, output, 2: 00 none, 01 illegal opcode, 10 memory timeout.
REQ-019 Port state_o, output, 3: current state encoding, for debug.

Function
REQ-020 States: FETCH=0, DECODE=1, EXECUTE=2, MEM_WAIT=3, WRITEBACK=4, TRAP=5. All outputs are Moore outputs decoded from the state and the latched opcode.
REQ-021 Opcode classes: ALU = 0000-0101 and 1001-1100; LOAD=0110; STORE=0111; LDI=1000; BRANCH=1101; JUMP=1110. 1111, or any nonzero bit above bit 3, is ILLEGAL.
REQ-022 FETCH: inst_wr=1, adrs_ctrl=1, mem_rd=1, pc_op=11. The FSM remains in FETCH until mem_ready=1, then latches opcode and moves to DECODE.
REQ-023 DECODE: en_reg=1. For LOAD/STORE: imm_en=1, adrs_ctrl=0; otherwise adrs_ctrl=1. ILLEGAL goes to TRAP with cause 01; all other opcodes go to EXECUTE.
REQ-024 EXECUTE outputs by class:
  - ALU: en_reg=1, adrs_ctrl=1.
  - LDI: imm_en=1.
  - LOAD/STORE: imm_en=1, adrs_ctrl=0.
  - BRANCH with flag=0: pc_op=01, imm_en=1.
  - BRANCH with flag=1: pc_op=11.
  - JUMP: pc_op=01, imm_en=1.
  - Next state: LOAD/STORE go to MEM_WAIT; all others go to WRITEBACK.
REQ-025 MEM_WAIT: imm_en=1, adrs_ctrl=0, plus mem_rd=1 (LOAD) or mem_wr=1 (STORE). The FSM stays until mem_ready=1, then moves to WRITEBACK.
REQ-026 Wait counter: cleared on entry to FETCH or MEM_WAIT; increments each cycle with mem_ready=0. When the counter equals WAIT_MAX with mem_ready=0, the FSM goes to TRAP with cause 10. mem_ready=1 on that same cycle SHALL win.
REQ-027 WRITEBACK: en_reg=1; regD_wr=1 for ALU, LDI and LOAD. pc_op=11 for BRANCH/JUMP, else 10. Next state: FETCH.
REQ-028 TRAP: all strobes 0, pc_op=11, trap=1, trap_cause held. trap_clr=1 moves to FETCH with pc_op=00 in that cycle and cause cleared.
REQ-029 Latency per instruction with mem_ready=1 on the first cycle: 4 cycles, or 5 cycles for LOAD/STORE.
REQ-030 mem_ready SHALL be ignored outside FETCH and MEM_WAIT; trap_clr SHALL be ignored outside TRAP.

Reset
REQ-031 While reset=1: state=FETCH, latched opcode=0, counter=0, trap_cause=00, and pc_op=00 overrides the FETCH decode. All other outputs take the FETCH values.
REQ-032 Reset asserted in any state, including mid-MEM_WAIT or TRAP, SHALL abort the operation immediately; no mem_wr pulse SHALL follow deassertion.

Structure
REQ-033 State encodings, opcode constants, pc_op codes and trap_cause codes SHALL live in the shared package ctrl_pkg.
REQ-034 The opcode classifier SHALL be one combinational sub-module, op_classify (opcode -> class one-hot and illegal).

Verification
REQ-035 ADD (0000), mem_ready=1 throughout -> FETCH, DECODE, EXECUTE, WRITEBACK; regD_wr=1 only in cycle 4; pc_op=10 in cycle 4.
REQ-036 LOAD (0110), mem_ready low for 3 MEM_WAIT cycles -> mem_rd=1 for 4 MEM_WAIT cycles; then WRITEBACK with regD_wr=1; total 8 cycles.
REQ-037 BRANCH (1101) with flag=0 -> pc_op=01 in EXECUTE and 11 in WRITEBACK; with flag=1 -> pc_op=11 in both.
REQ-038 Opcode 1111 -> TRAP after DECODE, trap_cause=01; hold 5 cycles; trap_clr=1 -> FETCH, pc_op=00, trap=0.
REQ-039 STORE with mem_ready=0 for 16 cycles (WAIT_MAX=15) -> TRAP with cause 10. Repeat with mem_ready=1 on the 15th wait cycle -> WRITEBACK, no trap.
REQ-040 Reset pulse mid-MEM_WAIT of a STORE -> mem_wr=0 immediately; state_o=0; next instruction fetched normally.
